// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transaction state naming and R/W bit encoding.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDevAddr,
    StDevAck,
    StRegAddr,
    StRegAck,
    StData,
    StDataAck
  } i2c_state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // True when an address byte selects this device for a write.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr) && (addr_byte[0] != I2C_READ);
  endfunction

endpackage

// File: rtl/i2c_slave_write_if.sv
// SCL input and register-write side of the write-only I2C target.
interface i2c_slave_write_if;
   logic       scl;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave  (input scl, output wr_valid, output wr_addr, output wr_data, output busy);
   modport master (output scl, input wr_valid, input wr_addr, input wr_data, input busy);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP event outputs.
module i2c_bus_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_bit
);

   // [0] metastable stage, [1] synchronized, [2] history
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_q     <= 3'b111;
         sda_q     <= 3'b111;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_bit   <= 1'b1;
      end else begin
         scl_q     <= {scl_q[1:0], scl};
         sda_q     <= {sda_q[1:0], sda};
         scl_rise  <= scl_q[1] & ~scl_q[2];
         scl_fall  <= ~scl_q[1] & scl_q[2];
         start_det <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
         stop_det  <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
         // Registered alongside the events so a sample lines up with its scl_rise.
         sda_bit   <= sda_q[1];
      end
   end

endmodule

// File: rtl/i2c_slave_write.sv
// Write-only I2C target: decodes START/addr/reg/data/STOP and strobes register writes.
module i2c_slave_write
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic                  clk,
   input  logic                  reset,
   inout  wire                   sda,
   i2c_slave_write_if.slave      bus
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl       (bus.scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_bit   (sda_bit)
   );

   i2c_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       wr_valid_q, wr_valid_d;
   logic       busy_q, busy_d;
   logic       ack_q, ack_d;
   logic       sda_drive_low;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
         wr_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_valid_d = 1'b0;
      busy_d     = busy_q;
      ack_d      = ack_q;

      // Bus conditions win over any bit sample in the same cycle.
      if (start_det) begin
         state_d   = StDevAddr;
         bit_cnt_d = 3'd0;
         busy_d    = 1'b0;
         ack_d     = 1'b0;
      end else if (stop_det) begin
         state_d   = StIdle;
         bit_cnt_d = 3'd0;
         busy_d    = 1'b0;
         ack_d     = 1'b0;
      end else begin
         case (state_q)
            StDevAddr, StRegAddr, StData: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_bit};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == StDevAddr) begin
                        if (addr_match(shift_d, SLAVE_ADDR)) begin
                           state_d = StDevAck;
                           busy_d  = 1'b1;
                        end else begin
                           state_d = StIdle;
                        end
                     end else if (state_q == StRegAddr) begin
                        wr_addr_d = shift_d;
                        state_d   = StRegAck;
                     end else begin
                        wr_data_d  = shift_d;
                        wr_valid_d = 1'b1;
                        state_d    = StDataAck;
                     end
                  end
               end
            end
            // First fall after bit 8 starts the ACK, the next one releases it.
            StDevAck, StRegAck, StDataAck: begin
               if (scl_fall) begin
                  ack_d = ~ack_q;
                  if (ack_q) begin
                     if (state_q == StDataAck) begin
                        wr_addr_d = wr_addr_q + 8'd1;
                     end
                     state_d = (state_q == StDevAck) ? StRegAddr : StData;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.wr_valid  = wr_valid_q;
      bus.wr_addr   = wr_addr_q;
      bus.wr_data   = wr_data_q;
      bus.busy      = busy_q;
      sda_drive_low = ack_q;
   end

   assign sda = sda_drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_write.sv
// Directed bench for i2c_slave_write: bit-banged master plus write-strobe scoreboard.
module tb_i2c_slave_write;
   import i2c_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic m_low = 1'b0;
   wire  sda;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_q[$];
   logic prev_valid = 1'b0;

   i2c_slave_write_if bus ();

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave_write #(
      .SLAVE_ADDR (7'h50)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sda   (sda),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected (addr,data).
   always @(negedge clk) begin
      if (!reset && bus.wr_valid) begin
         n_tests++;
         if (prev_valid) begin
            n_fail++;
            $display("FAIL wr_valid_width: got 2+ cycle strobe, expected 1 cycle");
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, expected none",
                     bus.wr_addr, bus.wr_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({bus.wr_addr, bus.wr_data} != e) begin
               n_fail++;
               $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                        bus.wr_addr, bus.wr_data, e[15:8], e[7:0]);
            end
         end
      end
      prev_valid <= bus.wr_valid;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic bit_out(input logic b);
      clk_wait(4);
      m_low = ~b;
      clk_wait(4);
      bus.scl = 1'b1;
      clk_wait(8);
      bus.scl = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) bit_out(b[i]);
   endtask

   task automatic get_ack(output int ack);
      clk_wait(4);
      m_low = 1'b0;
      clk_wait(4);
      bus.scl = 1'b1;
      clk_wait(4);
      ack = (sda === 1'b0) ? 1 : 0;
      clk_wait(4);
      bus.scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int exp_ack, input string name);
      int a;
      send_bits(b, 8);
      get_ack(a);
      check(name, a, exp_ack);
   endtask

   task automatic bus_start();
      clk_wait(4);
      m_low = 1'b0;
      clk_wait(4);
      bus.scl = 1'b1;
      clk_wait(8);
      m_low = 1'b1;
      clk_wait(8);
      bus.scl = 1'b0;
   endtask

   task automatic bus_stop();
      clk_wait(4);
      m_low = 1'b1;
      clk_wait(4);
      bus.scl = 1'b1;
      clk_wait(8);
      m_low = 1'b0;
      clk_wait(8);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.scl = 1'b1;
      clk_wait(3);
      reset = 1'b0;
      clk_wait(2);
      check("rst_sda", (sda === 1'b1) ? 1 : 0, 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_wr_valid", int'(bus.wr_valid), 0);
      check("rst_wr_addr", int'(bus.wr_addr), 8'h00);
      check("rst_wr_data", int'(bus.wr_data), 8'h00);

      // Addressed write
      exp_q.push_back({8'h12, 8'h5A});
      bus_start();
      send_byte(8'hA0, 1, "w1_dev_ack");
      check("w1_busy", int'(bus.busy), 1);
      send_byte(8'h12, 1, "w1_reg_ack");
      send_byte(8'h5A, 1, "w1_data_ack");
      bus_stop();
      check("w1_busy_after_stop", int'(bus.busy), 0);

      // Address mismatch: everything NACKed, no write
      bus_start();
      send_byte(8'hA2, 0, "mm_dev_nack");
      send_byte(8'h12, 0, "mm_reg_nack");
      send_byte(8'h5A, 0, "mm_data_nack");
      check("mm_busy", int'(bus.busy), 0);
      bus_stop();

      // Read request: NACK and back to idle
      bus_start();
      send_byte({7'h50, I2C_READ}, 0, "rd_nack");
      check("rd_idle", (dut.state_q == StIdle) ? 1 : 0, 1);
      check("rd_busy", int'(bus.busy), 0);
      bus_stop();

      // Burst with register address wrap
      exp_q.push_back({8'hFE, 8'h11});
      exp_q.push_back({8'hFF, 8'h22});
      exp_q.push_back({8'h00, 8'h33});
      bus_start();
      send_byte(8'hA0, 1, "bu_dev_ack");
      send_byte(8'hFE, 1, "bu_reg_ack");
      send_byte(8'h11, 1, "bu_d0_ack");
      send_byte(8'h22, 1, "bu_d1_ack");
      send_byte(8'h33, 1, "bu_d2_ack");
      bus_stop();
      check("bu_busy_after_stop", int'(bus.busy), 0);

      // STOP after 4 data bits: partial byte dropped
      bus_start();
      send_byte(8'hA0, 1, "ab_dev_ack");
      send_byte(8'h40, 1, "ab_reg_ack");
      send_bits(8'hC3, 4);
      bus_stop();
      check("ab_busy", int'(bus.busy), 0);

      // Repeated START mid register byte, then a normal write
      exp_q.push_back({8'h30, 8'h77});
      bus_start();
      send_byte({7'h50, I2C_WRITE}, 1, "rs_dev_ack");
      send_bits(8'h55, 3);
      bus_start();
      check("rs_busy_cleared", int'(bus.busy), 0);
      send_byte(8'hA0, 1, "rs_dev_ack2");
      send_byte(8'h30, 1, "rs_reg_ack");
      send_byte(8'h77, 1, "rs_data_ack");
      bus_stop();

      // Reset while the device-address ACK is being driven
      bus_start();
      send_bits(8'hA0, 8);
      clk_wait(4);
      m_low = 1'b0;
      clk_wait(4);
      bus.scl = 1'b1;
      clk_wait(2);
      check("ra_sda_driven", (sda === 1'b0) ? 1 : 0, 1);
      #2;
      reset = 1'b1;
      #1;
      check("ra_sda_released", (sda === 1'b1) ? 1 : 0, 1);
      check("ra_busy", int'(bus.busy), 0);
      check("ra_wr_valid", int'(bus.wr_valid), 0);
      check("ra_wr_addr", int'(bus.wr_addr), 8'h00);
      check("ra_wr_data", int'(bus.wr_data), 8'h00);
      clk_wait(3);
      reset = 1'b0;
      clk_wait(20);

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_write.md
# i2c_slave_write

Write-only I2C target: the receiving end of the team's I2C master write transaction (START, 7-bit address + W, register-address byte, data byte(s), STOP). The block oversamples SCL/SDA on the system clock and ACKs matching frames by pulling SDA low. Each received data byte is presented on a one-cycle register-write strobe to the local register file. SCL is input-only, with no clock stretching.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit device address this block answers to.
- clk  in  1  system clock; also the SCL/SDA oversampling clock.
- reset  in  1  asynchronous, active-high reset.
- scl  in  1  I2C clock from the master; pulled up externally.
- sda  inout  1  open-drain; the block drives only 0 (ACK) or Z.
- wr_valid  out  1  one-cycle strobe: wr_addr/wr_data hold a complete write.
- wr_addr  out  8  register address for the current data byte.
- wr_data  out  8  received data byte.
- busy  out  1  high from an accepted address match until STOP or abort.

## Operation
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus one history flop.
  - Rise and fall events are taken from the synchronized pair.
- Bus events:
  - START: sda fall while scl is high in both history samples.
  - STOP: sda rise while scl is high in both history samples.
- Bit handling:
  - Data bits are sampled on the scl-rise event.
  - ACK drive changes on the scl-fall event.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, DATA, DATA_ACK. A 3-bit bit counter and an 8-bit MSB-first shift register are shared across byte states.
- IDLE -> DEV_ADDR on START. Counter cleared.
- DEV_ADDR: shift 8 bits. On the 8th sample, check the byte:
  - If [7:1]==SLAVE_ADDR and [0]==0, go to DEV_ACK.
  - Otherwise (mismatch or read request), go to IDLE with no ACK. The block then ignores the bus until the next START.
- DEV_ACK:
  - Drive sda=0 from the next scl-fall through the following scl-fall.
  - Then release sda and go to REG_ADDR. busy is set on entry.
- REG_ADDR: shift 8 bits, load wr_addr, go to REG_ACK. REG_ACK is the same as DEV_ACK, then go to DATA.
- DATA: shift 8 bits. On the 8th sample:
  - Load wr_data and pulse wr_valid for exactly one clk.
  - Go to DATA_ACK. DATA_ACK is the same as DEV_ACK.
- DATA_ACK exit:
  - wr_addr increments (8-bit, 0xFF wraps to 0x00) on the release edge.
  - Return to DATA for further bytes.
  - Every data byte is ACKed.
- STOP in any state -> IDLE: sda released, busy cleared, partial byte discarded (no wr_valid).
- Repeated START in any state -> DEV_ADDR: sda released, counter cleared, busy cleared until the next address match.
- A START/STOP detected in the same clk as a bit sample takes priority; the sample is dropped.

## Timing
- Reset values:
  - sda released (Z).
  - wr_valid=0, wr_addr=8'h00, wr_data=8'h00, busy=0.
  - State IDLE, counter 0.
- Reset mid-ACK releases sda asynchronously, with no clk edge required.
- Synchronizer + edge detect latency: 3 clk from pin change to event.
- Hence SCL high and low phases must each be at least 4 clk, and the SDA setup to scl rise at least 3 clk.
- The team master (scl toggles every 4 clk of the same clock) meets this with zero margin. Targets slower than that are recommended.
- wr_valid asserts 1 clk after the scl-rise event of the 8th data bit, i.e. 4 clk after the pin edge.
- ACK drive:
  - Asserts 1 clk after the scl-fall event following bit 8.
  - Held until 1 clk after the next scl-fall event.
- wr_addr/wr_data remain stable between strobes.

## Structure
- Package i2c_pkg:
  - State enum typedef (shared with the master's state naming).
  - Constants I2C_WRITE=1'b0 and I2C_READ=1'b1.
- Sub-module i2c_bus_sync: synchronizers plus scl_rise, scl_fall, start_det and stop_det outputs. Reusable by the master for ACK sampling.

## Test plan
- Addressed write, SLAVE_ADDR=7'h50:
  - Stimulus: START, 0xA0, 0x12, 0x5A, STOP.
  - Required: 3 ACKs on sda; one wr_valid with wr_addr=0x12, wr_data=0x5A; busy low after STOP.
- Address mismatch:
  - Stimulus: START, 0xA2, 0x12, 0x5A, STOP.
  - Required: sda never driven; no wr_valid; busy stays 0.
- Read request:
  - Stimulus: START, 0xA1.
  - Required: NACK (sda Z on the 9th clock); state returns to IDLE.
- Burst with wrap:
  - Stimulus: START, 0xA0, 0xFE, 0x11, 0x22, 0x33, STOP.
  - Required: wr_valid strobes (0xFE,0x11), (0xFF,0x22), (0x00,0x33).
- Abort mid-byte:
  - Stimulus: STOP after 4 data bits.
  - Required: no wr_valid.
  - Then a repeated START mid-REG_ADDR followed by a full write is accepted normally.
- Reset during DEV_ACK:
  - Stimulus: assert reset while sda is driven low.
  - Required: sda goes Z immediately and all outputs return to reset values.
